booth_r4_seq_mult: RTL

Parametrised sequential radix-4 Booth multiplier. Retires one Booth digit per clock and supports signed or unsigned operands per transaction. Uses a valid/ready handshake on both input and output, plus a global enable stall. It is the drop-in successor to the fixed 32-bit registered Booth multiplier in the arithmetic datapath.

---
 rtl/booth_pkg.sv | 30 +++
 rtl/booth_r4_pp_gen.sv | 27 ++
 rtl/booth_r4_seq_mult.sv | 101 ++++++++++
 3 files changed

// File: rtl/booth_pkg.sv
// Shared types for the radix-4 Booth multiplier: FSM states, Booth digits and
// the triplet-to-digit encoder.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        ZERO = 3'd0,
        POS1 = 3'd1,
        POS2 = 3'd2,
        NEG1 = 3'd3,
        NEG2 = 3'd4
    } digit_t;

    // Triplet is {b[2i+1], b[2i], b[2i-1]}
    function automatic digit_t booth_encode(input logic [2:0] trip);
        case (trip)
            3'b001, 3'b010: return POS1;
            3'b011:         return POS2;
            3'b100:         return NEG2;
            3'b101, 3'b110: return NEG1;
            default:        return ZERO;
        endcase
    endfunction

endpackage

// File: rtl/booth_r4_pp_gen.sv
// Combinational radix-4 Booth partial-product generator: maps one triplet and
// the extended multiplicand to a 2*W2-bit two's-complement partial product.
module booth_r4_pp_gen
    import booth_pkg::*;
#(
    parameter int W2 = 34
) (
    input  logic        [2:0]      triplet,
    input  logic signed [W2-1:0]   a_ext,
    output logic signed [2*W2-1:0] pp
);

    logic signed [2*W2-1:0] a_wide;

    always_comb begin
        a_wide = {{W2{a_ext[W2-1]}}, a_ext};
        pp     = '0;
        case (booth_encode(triplet))
            POS1:    pp = a_wide;
            POS2:    pp = a_wide <<< 1;
            NEG1:    pp = -a_wide;
            NEG2:    pp = -(a_wide <<< 1);
            default: pp = '0;
        endcase
    end

endmodule

// File: rtl/booth_r4_seq_mult.sv
// Sequential radix-4 Booth multiplier, one digit per enabled clock, with
// valid/ready handshakes. Define BOOTH_EARLY_TERM_EN for data-dependent early finish.
module booth_r4_seq_mult
    import booth_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 is_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int W2 = WIDTH + 2;
    localparam int N  = W2 / 2;
    localparam int CW = $clog2(N) + 1;

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_RUN  = RUN;
    localparam logic [1:0] S_DONE = DONE;

    logic [1:0]               state_p0;
    logic signed [W2-1:0]     a_ext_p0;
    logic [W2:0]              b_sh_p0;
    logic signed [2*W2-1:0]   acc_p0;
    logic [CW-1:0]            cnt_p0;
    logic [2*WIDTH-1:0]       product_p1;

    logic signed [2*W2-1:0]   pp;
    logic signed [2*W2-1:0]   acc_next;
    logic                     last_digit;

    // b_sh holds {b_ext, 0} shifted right by 2 per digit, so bits [2:0] are the current triplet
    booth_r4_pp_gen #(.W2(W2)) u_pp_gen (
        .triplet (b_sh_p0[2:0]),
        .a_ext   (a_ext_p0),
        .pp      (pp)
    );

    assign acc_next = acc_p0 + (pp <<< {cnt_p0, 1'b0});

`ifdef BOOTH_EARLY_TERM_EN
    // Sign-filled shift keeps b_sh[W2:2] equal to b_ext[W2-1:2i+1] padded with its MSB
    logic rest_eq;
    assign rest_eq    = (&b_sh_p0[W2:2]) | ~(|b_sh_p0[W2:2]);
    assign last_digit = (cnt_p0 == CW'(N - 1)) | rest_eq;
`else
    assign last_digit = (cnt_p0 == CW'(N - 1));
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_p0   <= S_IDLE;
            a_ext_p0   <= '0;
            b_sh_p0    <= '0;
            acc_p0     <= '0;
            cnt_p0     <= '0;
            product_p1 <= '0;
        end else if (en) begin
            case (state_p0)
                S_IDLE: begin
                    if (in_valid) begin
                        a_ext_p0 <= {{2{is_signed & a[WIDTH-1]}}, a};
                        b_sh_p0  <= {{2{is_signed & b[WIDTH-1]}}, b, 1'b0};
                        acc_p0   <= '0;
                        cnt_p0   <= '0;
                        state_p0 <= S_RUN;
                    end
                end
                S_RUN: begin
                    acc_p0  <= acc_next;
                    cnt_p0  <= cnt_p0 + 1'b1;
                    b_sh_p0 <= {{2{b_sh_p0[W2]}}, b_sh_p0[W2:2]};
                    if (last_digit) begin
                        product_p1 <= acc_next[2*WIDTH-1:0];
                        state_p0   <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready)
                        state_p0 <= S_IDLE;
                end
                default: state_p0 <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_p0 == S_IDLE);
    assign out_valid = (state_p0 == S_DONE);
    assign busy      = (state_p0 == S_RUN);
    assign product   = product_p1;

endmodule
